// File: rtl/sdram_burst_master_if.sv
// Bundle of FIFO-side and SDRAM-controller-side signals for sdram_burst_master.
// master = the burst master itself, slave = the surrounding FIFOs/controller.
interface sdram_burst_master_if #(
  parameter int APP_ADDR_WIDTH  = 24,
  parameter int APP_BURST_WIDTH = 9,
  parameter int SDR_DQ_WIDTH    = 16,
  parameter int LEVEL_WIDTH     = 10,
  parameter int REGION_BURSTS   = 4
);
  localparam int FILL_W = $clog2(REGION_BURSTS + 1);

  logic                       enable;
  logic [LEVEL_WIDTH-1:0]     wr_fifo_level;
  logic [SDR_DQ_WIDTH-1:0]    wr_fifo_dout;
  logic                       wr_fifo_rd_en;
  logic [LEVEL_WIDTH-1:0]     rd_fifo_level;
  logic                       rd_fifo_wr_en;
  logic [SDR_DQ_WIDTH-1:0]    rd_fifo_din;

  logic                       wr_burst_req;
  logic [APP_BURST_WIDTH-1:0] wr_burst_len;
  logic [APP_ADDR_WIDTH-1:0]  wr_burst_addr;
  logic [SDR_DQ_WIDTH-1:0]    wr_burst_data;
  logic                       wr_burst_data_req;
  logic                       wr_burst_finish;

  logic                       rd_burst_req;
  logic [APP_BURST_WIDTH-1:0] rd_burst_len;
  logic [APP_ADDR_WIDTH-1:0]  rd_burst_addr;
  logic [SDR_DQ_WIDTH-1:0]    rd_burst_data;
  logic                       rd_burst_data_valid;
  logic                       rd_burst_finish;

  logic [FILL_W-1:0]          fill_bursts;

  modport master (
    input  enable, wr_fifo_level, wr_fifo_dout, rd_fifo_level,
    input  wr_burst_data_req, wr_burst_finish,
    input  rd_burst_data, rd_burst_data_valid, rd_burst_finish,
    output wr_fifo_rd_en, rd_fifo_wr_en, rd_fifo_din,
    output wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
    output rd_burst_req, rd_burst_len, rd_burst_addr,
    output fill_bursts
  );

  modport slave (
    output enable, wr_fifo_level, wr_fifo_dout, rd_fifo_level,
    output wr_burst_data_req, wr_burst_finish,
    output rd_burst_data, rd_burst_data_valid, rd_burst_finish,
    input  wr_fifo_rd_en, rd_fifo_wr_en, rd_fifo_din,
    input  wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
    input  rd_burst_req, rd_burst_len, rd_burst_addr,
    input  fill_bursts
  );
endinterface

// File: rtl/sdram_burst_master.sv
// Moves whole bursts between a write FIFO, an SDRAM ring buffer and a read FIFO.
// Define SDRAM_BURST_MASTER_RR_EN for round-robin arbitration; default is write-first.
module sdram_burst_master #(
  parameter int APP_ADDR_WIDTH  = 24,
  parameter int APP_BURST_WIDTH = 9,
  parameter int SDR_DQ_WIDTH    = 16,
  parameter int LEVEL_WIDTH     = 10,
  parameter int BURST_LEN       = 256,
  parameter int REGION_BURSTS   = 4,
  parameter int BASE_ADDR       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  sdram_burst_master_if.master  bus
);
  localparam int FILL_W = $clog2(REGION_BURSTS + 1);
  localparam int PTR_W  = (REGION_BURSTS > 1) ? $clog2(REGION_BURSTS) : 1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_REQ  = 3'd1;
  localparam logic [2:0] WR_WAIT = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_WAIT = 3'd4;

  localparam logic [PTR_W-1:0]       PTR_LAST  = PTR_W'(REGION_BURSTS - 1);
  localparam logic [FILL_W-1:0]      FILL_FULL = FILL_W'(REGION_BURSTS);
  localparam logic [LEVEL_WIDTH:0]   BURST_LVL = (LEVEL_WIDTH + 1)'(BURST_LEN);
  localparam logic [LEVEL_WIDTH:0]   LVL_MAX   = {1'b0, {LEVEL_WIDTH{1'b1}}};
  localparam logic [APP_ADDR_WIDTH-1:0] ADDR_BASE = APP_ADDR_WIDTH'(BASE_ADDR);
  localparam logic [APP_ADDR_WIDTH-1:0] ADDR_STEP = APP_ADDR_WIDTH'(BURST_LEN);

  logic [2:0]             state;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [FILL_W-1:0]      fill;
  logic                   wr_req;
  logic                   rd_req;
  logic [LEVEL_WIDTH:0]   rd_space;
  logic                   wr_ok;
  logic                   rd_ok;
  logic                   grant_wr;
  logic                   grant_rd;

  always_comb begin
    rd_space = LVL_MAX - {1'b0, bus.rd_fifo_level};
    wr_ok    = bus.enable && ({1'b0, bus.wr_fifo_level} >= BURST_LVL) && (fill < FILL_FULL);
    rd_ok    = bus.enable && (fill != '0) && (rd_space >= BURST_LVL);
  end

`ifdef SDRAM_BURST_MASTER_RR_EN
  logic last_rd;

  // When both sides are ready, serve whichever did not win the previous grant.
  always_comb begin
    grant_wr = wr_ok && (!rd_ok || last_rd);
    grant_rd = rd_ok && (!wr_ok || !last_rd);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_rd <= 1'b1;
    end else if (state == IDLE) begin
      if (grant_wr)      last_rd <= 1'b0;
      else if (grant_rd) last_rd <= 1'b1;
    end
  end
`else
  always_comb begin
    grant_wr = wr_ok;
    grant_rd = rd_ok && !wr_ok;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      wr_req <= 1'b0;
      rd_req <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_wr) begin
            state  <= WR_REQ;
            wr_req <= 1'b1;
          end else if (grant_rd) begin
            state  <= RD_REQ;
            rd_req <= 1'b1;
          end
        end
        WR_REQ: begin
          if (bus.wr_burst_data_req) begin
            state  <= WR_WAIT;
            wr_req <= 1'b0;
          end
        end
        WR_WAIT: begin
          if (bus.wr_burst_finish) begin
            state  <= IDLE;
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            fill   <= fill + 1'b1;
          end
        end
        RD_REQ: begin
          if (bus.rd_burst_data_valid) begin
            state  <= RD_WAIT;
            rd_req <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (bus.rd_burst_finish) begin
            state  <= IDLE;
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            fill   <= fill - 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          wr_req <= 1'b0;
          rd_req <= 1'b0;
        end
      endcase
    end
  end

  // Pointers only move on finish, so the addresses hold for the whole burst.
  assign bus.wr_burst_addr = ADDR_BASE + APP_ADDR_WIDTH'(wr_ptr) * ADDR_STEP;
  assign bus.rd_burst_addr = ADDR_BASE + APP_ADDR_WIDTH'(rd_ptr) * ADDR_STEP;
  assign bus.wr_burst_len  = APP_BURST_WIDTH'(BURST_LEN);
  assign bus.rd_burst_len  = APP_BURST_WIDTH'(BURST_LEN);
  assign bus.wr_burst_req  = wr_req;
  assign bus.rd_burst_req  = rd_req;
  assign bus.fill_bursts   = fill;

  assign bus.wr_fifo_rd_en = bus.wr_burst_data_req;
  assign bus.wr_burst_data = bus.wr_fifo_dout;
  assign bus.rd_fifo_wr_en = bus.rd_burst_data_valid;
  assign bus.rd_fifo_din   = bus.rd_burst_data;
endmodule

// File: tb/tb_sdram_burst_master.sv
// Randomized bench for sdram_burst_master: a controller/FIFO emulator plus a
// counting reference model of ring occupancy, burst addresses and arbitration.
module tb_sdram_burst_master;
  localparam int BL   = 256;
  localparam int RB   = 4;
  localparam int BASE = 0;
  localparam int LW   = 10;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  // reference model: bursts written/read since reset and who won last
  int   m_fill;
  int   m_wr;
  int   m_rd;
  bit   m_last_rd;
  bit   cur_en;
  int   cur_wl;
  int   cur_rl;

  sdram_burst_master_if bus ();

  sdram_burst_master dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int wr_addr_exp();
    return BASE + (m_wr % RB) * BL;
  endfunction

  function automatic int rd_addr_exp();
    return BASE + (m_rd % RB) * BL;
  endfunction

  // 0 = nothing, 1 = write burst, 2 = read burst
  function automatic int predict();
    bit we;
    bit re;
    we = cur_en && (cur_wl >= BL) && (m_fill < RB);
    re = cur_en && (m_fill > 0) && (((1 << LW) - 1 - cur_rl) >= BL);
    if (we && re) begin
`ifdef SDRAM_BURST_MASTER_RR_EN
      return m_last_rd ? 1 : 2;
`else
      return 1;
`endif
    end
    if (we) return 1;
    if (re) return 2;
    return 0;
  endfunction

  task automatic apply(input bit en, input int wl, input int rl);
    cur_en = en;
    cur_wl = wl;
    cur_rl = rl;
    bus.enable        = en;
    bus.wr_fifo_level = LW'(wl);
    bus.rd_fifo_level = LW'(rl);
  endtask

  task automatic model_reset();
    m_fill    = 0;
    m_wr      = 0;
    m_rd      = 0;
    m_last_rd = 1'b1;
  endtask

  task automatic wait_req(output int t);
    t = 0;
    while (!bus.wr_burst_req && !bus.rd_burst_req && t < 20) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic serve(input int exp_kind, input bit drop_en);
    int t;
    int kind;
    int pulses;
    int dmis;
    if (exp_kind == 0) begin
      repeat (8) @(negedge clk);
      chk("no_req", 32'({bus.wr_burst_req, bus.rd_burst_req}), 0);
      return;
    end
    wait_req(t);
    if (t >= 20) begin
      chk("req_timeout", t, 0);
      return;
    end
    kind = bus.wr_burst_req ? 1 : 2;
    chk("grant", kind, exp_kind);
    chk("one_req", 32'(bus.wr_burst_req & bus.rd_burst_req), 0);
    m_last_rd = (kind == 2);
    if (drop_en) bus.enable = 1'b0;
    pulses = 0;
    dmis   = 0;
    if (kind == 1) begin
      chk("wr_addr", 32'(bus.wr_burst_addr), wr_addr_exp());
      chk("wr_len", 32'(bus.wr_burst_len), BL);
      for (int i = 0; i < BL; i++) begin
        bus.wr_burst_data_req = 1'b1;
        bus.wr_fifo_dout      = 16'($urandom);
        #1;
        if (bus.wr_fifo_rd_en) pulses++;
        if (bus.wr_burst_data !== bus.wr_fifo_dout) dmis++;
        @(negedge clk);
        if (i == 0) chk("wr_req_drop", 32'(bus.wr_burst_req), 0);
      end
      bus.wr_burst_data_req = 1'b0;
      chk("wr_pulses", pulses, BL);
      chk("wr_data", dmis, 0);
      bus.rd_burst_finish = 1'b1;
      @(negedge clk);
      bus.rd_burst_finish = 1'b0;
      chk("wr_addr_hold", 32'(bus.wr_burst_addr), wr_addr_exp());
      chk("stray_rd_fin", 32'(bus.fill_bursts), m_fill);
      bus.wr_burst_finish = 1'b1;
      @(negedge clk);
      bus.wr_burst_finish = 1'b0;
      m_wr++;
      m_fill++;
    end else begin
      chk("rd_addr", 32'(bus.rd_burst_addr), rd_addr_exp());
      chk("rd_len", 32'(bus.rd_burst_len), BL);
      for (int i = 0; i < BL; i++) begin
        bus.rd_burst_data_valid = 1'b1;
        bus.rd_burst_data       = 16'($urandom);
        #1;
        if (bus.rd_fifo_wr_en) pulses++;
        if (bus.rd_fifo_din !== bus.rd_burst_data) dmis++;
        @(negedge clk);
        if (i == 0) chk("rd_req_drop", 32'(bus.rd_burst_req), 0);
      end
      bus.rd_burst_data_valid = 1'b0;
      chk("rd_pulses", pulses, BL);
      chk("rd_data", dmis, 0);
      bus.wr_burst_finish = 1'b1;
      @(negedge clk);
      bus.wr_burst_finish = 1'b0;
      chk("rd_addr_hold", 32'(bus.rd_burst_addr), rd_addr_exp());
      chk("stray_wr_fin", 32'(bus.fill_bursts), m_fill);
      bus.rd_burst_finish = 1'b1;
      @(negedge clk);
      bus.rd_burst_finish = 1'b0;
      m_rd++;
      m_fill--;
    end
    chk("idle_gap", 32'({bus.wr_burst_req, bus.rd_burst_req}), 0);
    chk("fill", 32'(bus.fill_bursts), m_fill);
    chk("wr_addr_next", 32'(bus.wr_burst_addr), wr_addr_exp());
    chk("rd_addr_next", 32'(bus.rd_burst_addr), rd_addr_exp());
    if (drop_en) bus.enable = cur_en;
  endtask

  task automatic step(input bit en, input int wl, input int rl, input bit drop_en);
    apply(en, wl, rl);
    serve(predict(), drop_en);
  endtask

  initial begin
    int t;
    int wl;
    int rl;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.wr_fifo_dout        = '0;
    bus.wr_burst_data_req   = 1'b0;
    bus.wr_burst_finish     = 1'b0;
    bus.rd_burst_data       = '0;
    bus.rd_burst_data_valid = 1'b0;
    bus.rd_burst_finish     = 1'b0;
    apply(1'b0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_wr_req", 32'(bus.wr_burst_req), 0);
    chk("rst_rd_req", 32'(bus.rd_burst_req), 0);
    chk("rst_fill", 32'(bus.fill_bursts), 0);
    chk("rst_wr_addr", 32'(bus.wr_burst_addr), BASE);
    chk("rst_rd_addr", 32'(bus.rd_burst_addr), BASE);
    rst = 1'b0;

    // first write, then read it back
    step(1'b1, 256, 1023, 1'b0);
    chk("first_fill", 32'(bus.fill_bursts), 1);
    chk("first_wr_ptr", 32'(bus.wr_burst_addr), 256);
    step(1'b1, 0, 0, 1'b0);
    chk("drain_fill", 32'(bus.fill_bursts), 0);

    // fill the ring with the read FIFO full, then a fifth write must not start
    for (int i = 0; i < 4; i++) step(1'b1, 256, 1023, i == 2);
    chk("full_fill", 32'(bus.fill_bursts), 4);
    step(1'b1, 300, 1023, 1'b0);

    // drain everything; the fifth read wraps to the base address
    for (int i = 0; i < 4; i++) step(1'b1, 0, 0, 1'b0);
    step(1'b1, 0, 0, 1'b0);
    step(1'b1, 255, 0, 1'b0);
    step(1'b1, 256, 768, 1'b0);
    step(1'b1, 0, 768, 1'b0);
    step(1'b1, 0, 767, 1'b0);

    // set up fill=1 with read last served, then both eligible for 4 grants
    step(1'b1, 256, 1023, 1'b0);
    step(1'b1, 256, 1023, 1'b0);
    step(1'b1, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 256, 0, 1'b0);

    // finish pulses while idle must not move anything
    apply(1'b0, 256, 0);
    bus.wr_burst_finish = 1'b1;
    bus.rd_burst_finish = 1'b1;
    @(negedge clk);
    bus.wr_burst_finish = 1'b0;
    bus.rd_burst_finish = 1'b0;
    @(negedge clk);
    chk("idle_fin_fill", 32'(bus.fill_bursts), m_fill);
    chk("idle_fin_wr", 32'(bus.wr_burst_addr), wr_addr_exp());
    chk("idle_fin_rd", 32'(bus.rd_burst_addr), rd_addr_exp());

    // reset in the middle of a write burst
    apply(1'b1, 256, 1023);
    wait_req(t);
    chk("mid_grant", 32'(bus.wr_burst_req), 1);
    bus.wr_burst_data_req = 1'b1;
    @(negedge clk);
    bus.wr_burst_data_req = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_wr_req", 32'(bus.wr_burst_req), 0);
    chk("mid_rst_rd_req", 32'(bus.rd_burst_req), 0);
    chk("mid_rst_fill", 32'(bus.fill_bursts), 0);
    chk("mid_rst_wr_addr", 32'(bus.wr_burst_addr), BASE);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1'b1, 256, 1023, 1'b0);

    // random traffic
    for (int n = 0; n < 30; n++) begin
      case ($urandom % 3)
        0:       wl = 255;
        1:       wl = 256;
        default: wl = int'($urandom % 1024);
      endcase
      case ($urandom % 3)
        0:       rl = 767;
        1:       rl = 768;
        default: rl = int'($urandom % 1024);
      endcase
      step(($urandom % 6) != 0, wl, rl, ($urandom % 4) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
